// File: rtl/datmem_arb.sv
// Two-port valid/ready arbiter and word sequencer in front of the single-port datmem.
// Define DATMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module datmem_arb #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wrt,
    input  logic [31:0] req_ad0,
    input  logic [31:0] req_ad1,
    input  logic [31:0] req_dat0,
    input  logic [31:0] req_dat1,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_dat,
    output logic [31:0] mem_ad,
    output logic [31:0] writ_dat,
    output logic        mem_wrt,
    input  logic [31:0] red_dat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic [31:0] mem_ad_q, mem_ad_d;
    logic [31:0] writ_dat_q, writ_dat_d;
    logic        mem_wrt_q, mem_wrt_d;
    logic        owner_q, owner_d;

    logic        gnt;
    logic        accept;
    logic [31:0] sel_ad;
    logic [31:0] sel_dat;
    logic        sel_wrt;
    logic        sel_err;

`ifdef DATMEM_ARB_RR_EN
    logic rr_last_q, rr_last_d;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        gnt = ~req_valid[0];
        if (req_valid == 2'b11) begin
            gnt = ~rr_last_q;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (accept) begin
            rr_last_d = gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    always_comb begin
        gnt = ~req_valid[0];
    end
`endif

    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE) begin
            req_ready = (gnt ? 2'b10 : 2'b01) & req_valid;
        end
    end

    assign accept  = |(req_valid & req_ready);
    assign sel_ad  = gnt ? req_ad1 : req_ad0;
    assign sel_dat = gnt ? req_dat1 : req_dat0;
    assign sel_wrt = gnt ? req_wrt[1] : req_wrt[0];
    assign sel_err = (sel_ad[1:0] != 2'b00) ||
                     ({2'b00, sel_ad[31:2]} >= 32'(WORDS));

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = 32'h0;
        mem_ad_d    = mem_ad_q;
        writ_dat_d  = writ_dat_q;
        mem_wrt_d   = 1'b0;
        owner_d     = owner_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gnt;
                    if (sel_err) begin
                        rsp_valid_d = gnt ? 2'b10 : 2'b01;
                        rsp_err_d   = 1'b1;
                    end else begin
                        mem_ad_d   = sel_ad;
                        writ_dat_d = sel_dat;
                        mem_wrt_d  = sel_wrt;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // mem_wrt_q still marks a store here; loads wait for red_dat.
                if (mem_wrt_q) begin
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = IDLE;
                end else begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                rsp_dat_d   = red_dat;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 32'h0;
            mem_ad_q    <= 32'h0;
            writ_dat_q  <= 32'h0;
            mem_wrt_q   <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            mem_ad_q    <= mem_ad_d;
            writ_dat_q  <= writ_dat_d;
            mem_wrt_q   <= mem_wrt_d;
            owner_q     <= owner_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;
    assign mem_ad    = mem_ad_q;
    assign writ_dat  = writ_dat_q;
    assign mem_wrt   = mem_wrt_q;

endmodule
